interrupt_sequencer: RTL and testbench



---
 rtl/interrupt_sequencer_if.sv | 74 +++++++
 rtl/interrupt_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/interrupt_sequencer_if.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer_if
//
// Bundle of every non-clock signal between the interrupt sequencer and the
// CPU core / data memory / timer interrupt controller.
//
// Modports:
//   master : the interrupt sequencer (samples core/irq inputs, drives strobes)
//   slave  : the core-side environment (drives irq/pc/sp/mem_rdata)
//
// Signals (direction as seen by the sequencer):
//   irq            in   interrupt request from the interrupt controller
//   vector         in   ISR address presented with irq
//   instr_boundary in   core is at a fetch boundary and may be preempted
//   reti           in   RETI decoded at this boundary
//   pc             in   return address (next PC)
//   sp             in   current stack pointer
//   mem_rdata      in   data-memory read data, valid one cycle after mem_re
//   stall          out  hold core pipeline
//   mem_addr       out  data-memory address
//   mem_wdata      out  data-memory write data
//   mem_we/mem_re  out  write / read strobes
//   sp_wr_en       out  load sp_next into SP
//   sp_next        out  new SP value
//   pc_load        out  load pc_target into PC
//   pc_target      out  new PC value
//   sreg_i_clr/set out  clear / set the global I flag
//   tifr_clr_mask  out  write-one-to-clear mask for TIFR
//   busy           out  sequencer is not idle
//
// Handshake: there is no valid/ready pair here. Every strobe (mem_we, mem_re,
// sp_wr_en, pc_load, sreg_i_clr, sreg_i_set) is a single-cycle command that
// the receiver must act on in the cycle it is high; the receiver cannot
// back-pressure. mem_rdata is expected exactly one cycle after mem_re.
// -----------------------------------------------------------------------------
interface interrupt_sequencer_if #(
  parameter int DATA_WIDTH   = 8,
  parameter int I_ADDR_WIDTH = 10,
  parameter int D_ADDR_WIDTH = 8
);
  logic                    irq;
  logic [I_ADDR_WIDTH-1:0] vector;
  logic                    instr_boundary;
  logic                    reti;
  logic [I_ADDR_WIDTH-1:0] pc;
  logic [D_ADDR_WIDTH-1:0] sp;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  logic                    stall;
  logic [D_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_we;
  logic                    mem_re;
  logic                    sp_wr_en;
  logic [D_ADDR_WIDTH-1:0] sp_next;
  logic                    pc_load;
  logic [I_ADDR_WIDTH-1:0] pc_target;
  logic                    sreg_i_clr;
  logic                    sreg_i_set;
  logic [DATA_WIDTH-1:0]   tifr_clr_mask;
  logic                    busy;

  modport master (
    input  irq, vector, instr_boundary, reti, pc, sp, mem_rdata,
    output stall, mem_addr, mem_wdata, mem_we, mem_re, sp_wr_en, sp_next,
           pc_load, pc_target, sreg_i_clr, sreg_i_set, tifr_clr_mask, busy
  );

  modport slave (
    output irq, vector, instr_boundary, reti, pc, sp, mem_rdata,
    input  stall, mem_addr, mem_wdata, mem_we, mem_re, sp_wr_en, sp_next,
           pc_load, pc_target, sreg_i_clr, sreg_i_set, tifr_clr_mask, busy
  );
endinterface

// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
//
// CPU-side responder for the timer interrupt controller.
//   Entry  : at an instruction boundary with irq (and no one-instruction hold)
//            push the return PC (low byte at SP, high byte at SP-1), clear I,
//            acknowledge TIFR, jump to the vector, SP -= 2.
//   Return : at an instruction boundary with reti, read the PC back from
//            SP+1 (high) and SP+2 (low), set I, SP += 2, then hold off the
//            next interrupt for one instruction boundary.
//
// Ports:
//   clk         in   system clock
//   reset       in   synchronous, active-high reset
//   bus         master modport of interrupt_sequencer_if (see that file)
//   dbg_state_o out  current FSM state encoding (debug / checker hook)
//
// Optional feature: define IRQ_HW_ACK_EN to have the JUMP cycle drive a
// one-hot TIFR clear mask selected by the vector. Without it the mask is
// constant zero and ISRs clear their own flag.
//
// All outputs are registered: each state's outputs are loaded on the edge
// that enters that state. The one exception is pc_target in RET, which by
// construction combines the latched high byte with the low byte arriving on
// mem_rdata in that very cycle.
// -----------------------------------------------------------------------------
module interrupt_sequencer #(
  parameter int DATA_WIDTH   = 8,
  parameter int I_ADDR_WIDTH = 10,
  parameter int D_ADDR_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  interrupt_sequencer_if.master bus,
  output logic [2:0]           dbg_state_o
);

  // Width of the PC bits stored in the high stack byte. The design assumes
  // DATA_WIDTH < I_ADDR_WIDTH <= 2*DATA_WIDTH.
  localparam int HI_W = I_ADDR_WIDTH - DATA_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PUSH_LO = 3'd1,
    S_PUSH_HI = 3'd2,
    S_JUMP    = 3'd3,
    S_POP_HI  = 3'd4,
    S_POP_LO  = 3'd5,
    S_RET     = 3'd6
  } state_t;

  state_t                  state_q;
  logic                    hold_one_q;
  logic [I_ADDR_WIDTH-1:0] vec_q;
  logic [I_ADDR_WIDTH-1:0] pc_q;
  logic [D_ADDR_WIDTH-1:0] sp_q;
  logic [HI_W-1:0]         hi_q;

  // Registered outputs.
  logic                    busy_q;
  logic                    mem_we_q;
  logic                    mem_re_q;
  logic [D_ADDR_WIDTH-1:0] mem_addr_q;
  logic [DATA_WIDTH-1:0]   mem_wdata_q;
  logic                    sp_wr_en_q;
  logic [D_ADDR_WIDTH-1:0] sp_next_q;
  logic                    pc_load_q;
  logic [I_ADDR_WIDTH-1:0] pc_target_q;
  logic                    i_clr_q;
  logic                    i_set_q;

`ifdef IRQ_HW_ACK_EN
  // Timer 0 vector word addresses and TIFR bit positions.
  localparam logic [I_ADDR_WIDTH-1:0] TIM0_COMPA_ISR = I_ADDR_WIDTH'(28);
  localparam logic [I_ADDR_WIDTH-1:0] TIM0_COMPB_ISR = I_ADDR_WIDTH'(30);
  localparam logic [I_ADDR_WIDTH-1:0] TIM0_OVF_ISR   = I_ADDR_WIDTH'(32);
  localparam int TOV0  = 0;
  localparam int OCF0A = 1;
  localparam int OCF0B = 2;

  logic [DATA_WIDTH-1:0] tifr_mask_q;

  // One-hot acknowledge for the three timer-0 sources, zero for anything else.
  function automatic logic [DATA_WIDTH-1:0] ack_mask(
    input logic [I_ADDR_WIDTH-1:0] v
  );
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    if (v == TIM0_OVF_ISR)        m[TOV0]  = 1'b1;
    else if (v == TIM0_COMPA_ISR) m[OCF0A] = 1'b1;
    else if (v == TIM0_COMPB_ISR) m[OCF0B] = 1'b1;
    return m;
  endfunction
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hold_one_q  <= 1'b0;
      vec_q       <= '0;
      pc_q        <= '0;
      sp_q        <= '0;
      hi_q        <= '0;
      busy_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sp_wr_en_q  <= 1'b0;
      sp_next_q   <= '0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
      i_clr_q     <= 1'b0;
      i_set_q     <= 1'b0;
`ifdef IRQ_HW_ACK_EN
      tifr_mask_q <= '0;
`endif
    end else begin
      // Every output defaults to zero so strobes last exactly one cycle and
      // buses read as zero outside the state that owns them.
      busy_q      <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      sp_wr_en_q  <= 1'b0;
      sp_next_q   <= '0;
      pc_load_q   <= 1'b0;
      pc_target_q <= '0;
      i_clr_q     <= 1'b0;
      i_set_q     <= 1'b0;
`ifdef IRQ_HW_ACK_EN
      tifr_mask_q <= '0;
`endif

      case (state_q)
        S_IDLE: begin
          busy_q <= 1'b0;
          if (bus.instr_boundary) begin
            // Any boundary consumes the post-RETI hold; that same boundary
            // still cannot take an interrupt because the test below uses
            // the old hold value.
            hold_one_q <= 1'b0;
            if (bus.reti) begin
              sp_q       <= bus.sp;
              state_q    <= S_POP_HI;
              busy_q     <= 1'b1;
              mem_re_q   <= 1'b1;
              mem_addr_q <= bus.sp + D_ADDR_WIDTH'(1);
            end else if (bus.irq && !hold_one_q) begin
              vec_q       <= bus.vector;
              pc_q        <= bus.pc;
              sp_q        <= bus.sp;
              state_q     <= S_PUSH_LO;
              busy_q      <= 1'b1;
              mem_we_q    <= 1'b1;
              mem_addr_q  <= bus.sp;
              mem_wdata_q <= bus.pc[DATA_WIDTH-1:0];
            end
          end
        end

        S_PUSH_LO: begin
          state_q     <= S_PUSH_HI;
          mem_we_q    <= 1'b1;
          mem_addr_q  <= sp_q - D_ADDR_WIDTH'(1);
          mem_wdata_q <= DATA_WIDTH'(pc_q[I_ADDR_WIDTH-1:DATA_WIDTH]);
        end

        S_PUSH_HI: begin
          state_q     <= S_JUMP;
          pc_load_q   <= 1'b1;
          pc_target_q <= vec_q;
          i_clr_q     <= 1'b1;
          sp_wr_en_q  <= 1'b1;
          sp_next_q   <= sp_q - D_ADDR_WIDTH'(2);
`ifdef IRQ_HW_ACK_EN
          tifr_mask_q <= ack_mask(vec_q);
`endif
        end

        S_POP_HI: begin
          state_q    <= S_POP_LO;
          mem_re_q   <= 1'b1;
          mem_addr_q <= sp_q + D_ADDR_WIDTH'(2);
        end

        S_POP_LO: begin
          // Read data for the POP_HI access is on mem_rdata now.
          hi_q       <= bus.mem_rdata[HI_W-1:0];
          state_q    <= S_RET;
          pc_load_q  <= 1'b1;
          i_set_q    <= 1'b1;
          sp_wr_en_q <= 1'b1;
          sp_next_q  <= sp_q + D_ADDR_WIDTH'(2);
        end

        S_RET: begin
          hold_one_q <= 1'b1;
          state_q    <= S_IDLE;
          busy_q     <= 1'b0;
        end

        default: begin  // S_JUMP and unused encodings
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.stall      = busy_q;
  assign bus.busy       = busy_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_re     = mem_re_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.sp_wr_en   = sp_wr_en_q;
  assign bus.sp_next    = sp_next_q;
  assign bus.pc_load    = pc_load_q;
  assign bus.sreg_i_clr = i_clr_q;
  assign bus.sreg_i_set = i_set_q;
  // In RET the low byte is the POP_LO read data arriving this cycle.
  assign bus.pc_target  = (state_q == S_RET) ? {hi_q, bus.mem_rdata} : pc_target_q;
`ifdef IRQ_HW_ACK_EN
  assign bus.tifr_clr_mask = tifr_mask_q;
`else
  assign bus.tifr_clr_mask = '0;
`endif

  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_sequencer
//
// Directed bench for interrupt_sequencer: reset, entry, RETI return with irq
// held (priority + one-instruction hold), SP wrap on push and pop, reset abort
// during PUSH_HI, and the TIFR acknowledge mask. Inputs change and outputs are
// checked on the falling edge; a small byte memory answers reads one cycle
// after mem_re.
// -----------------------------------------------------------------------------
module tb_interrupt_sequencer;

  localparam int DW = 8;
  localparam int IW = 10;
  localparam int AW = 8;

  localparam logic [IW-1:0] V_COMPA = 10'h01C;
  localparam logic [IW-1:0] V_COMPB = 10'h01E;
  localparam logic [IW-1:0] V_OVF   = 10'h020;

`ifdef IRQ_HW_ACK_EN
  localparam logic [DW-1:0] M_OVF   = 8'h01;
  localparam logic [DW-1:0] M_COMPA = 8'h02;
  localparam logic [DW-1:0] M_COMPB = 8'h04;
`else
  localparam logic [DW-1:0] M_OVF   = 8'h00;
  localparam logic [DW-1:0] M_COMPA = 8'h00;
  localparam logic [DW-1:0] M_COMPB = 8'h00;
`endif

  // ---- clock / reset -------------------------------------------------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  interrupt_sequencer_if #(.DATA_WIDTH(DW), .I_ADDR_WIDTH(IW), .D_ADDR_WIDTH(AW)) bus ();
  logic [2:0] dbg_state;

  interrupt_sequencer #(.DATA_WIDTH(DW), .I_ADDR_WIDTH(IW), .D_ADDR_WIDTH(AW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .dbg_state_o(dbg_state)
  );

  // ---- data memory responder ----------------------------------------------
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  // ---- checking ------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".state"},   32'(dbg_state),   32'd0);
    chk({tag, ".stall"},   32'(bus.stall),   32'd0);
    chk({tag, ".busy"},    32'(bus.busy),    32'd0);
    chk({tag, ".we"},      32'(bus.mem_we),  32'd0);
    chk({tag, ".re"},      32'(bus.mem_re),  32'd0);
    chk({tag, ".pc_load"}, 32'(bus.pc_load), 32'd0);
    chk({tag, ".sp_wr"},   32'(bus.sp_wr_en), 32'd0);
  endtask

  task automatic chk_push(input string tag, input logic [7:0] addr,
                          input logic [7:0] data, input logic [2:0] st);
    chk({tag, ".state"}, 32'(dbg_state),     32'(st));
    chk({tag, ".stall"}, 32'(bus.stall),     32'd1);
    chk({tag, ".we"},    32'(bus.mem_we),    32'd1);
    chk({tag, ".re"},    32'(bus.mem_re),    32'd0);
    chk({tag, ".addr"},  32'(bus.mem_addr),  32'(addr));
    chk({tag, ".wdata"}, 32'(bus.mem_wdata), 32'(data));
  endtask

  task automatic chk_jump(input string tag, input logic [IW-1:0] tgt,
                          input logic [7:0] spn, input logic [7:0] mask);
    chk({tag, ".state"},   32'(dbg_state),         32'd3);
    chk({tag, ".stall"},   32'(bus.stall),         32'd1);
    chk({tag, ".we"},      32'(bus.mem_we),        32'd0);
    chk({tag, ".pc_load"}, 32'(bus.pc_load),       32'd1);
    chk({tag, ".target"},  32'(bus.pc_target),     32'(tgt));
    chk({tag, ".i_clr"},   32'(bus.sreg_i_clr),    32'd1);
    chk({tag, ".i_set"},   32'(bus.sreg_i_set),    32'd0);
    chk({tag, ".sp_wr"},   32'(bus.sp_wr_en),      32'd1);
    chk({tag, ".sp_next"}, 32'(bus.sp_next),       32'(spn));
    chk({tag, ".mask"},    32'(bus.tifr_clr_mask), 32'(mask));
  endtask

  task automatic chk_pop(input string tag, input logic [7:0] addr, input logic [2:0] st);
    chk({tag, ".state"}, 32'(dbg_state),    32'(st));
    chk({tag, ".stall"}, 32'(bus.stall),    32'd1);
    chk({tag, ".re"},    32'(bus.mem_re),   32'd1);
    chk({tag, ".we"},    32'(bus.mem_we),   32'd0);
    chk({tag, ".addr"},  32'(bus.mem_addr), 32'(addr));
  endtask

  task automatic chk_ret(input string tag, input logic [IW-1:0] tgt, input logic [7:0] spn);
    chk({tag, ".state"},   32'(dbg_state),         32'd6);
    chk({tag, ".stall"},   32'(bus.stall),         32'd1);
    chk({tag, ".pc_load"}, 32'(bus.pc_load),       32'd1);
    chk({tag, ".target"},  32'(bus.pc_target),     32'(tgt));
    chk({tag, ".i_set"},   32'(bus.sreg_i_set),    32'd1);
    chk({tag, ".i_clr"},   32'(bus.sreg_i_clr),    32'd0);
    chk({tag, ".sp_wr"},   32'(bus.sp_wr_en),      32'd1);
    chk({tag, ".sp_next"}, 32'(bus.sp_next),       32'(spn));
    chk({tag, ".mask"},    32'(bus.tifr_clr_mask), 32'd0);
  endtask

  // ---- directed sequence ---------------------------------------------------
  initial begin
    reset              = 1'b1;
    bus.irq            = 1'b0;
    bus.vector         = '0;
    bus.instr_boundary = 1'b0;
    bus.reti           = 1'b0;
    bus.pc             = '0;
    bus.sp             = '0;
    repeat (3) @(negedge clk);

    // Reset state: every output zero.
    chk_idle("reset");
    chk("reset.addr",    32'(bus.mem_addr),      32'd0);
    chk("reset.wdata",   32'(bus.mem_wdata),     32'd0);
    chk("reset.sp_next", 32'(bus.sp_next),       32'd0);
    chk("reset.target",  32'(bus.pc_target),     32'd0);
    chk("reset.i_clr",   32'(bus.sreg_i_clr),    32'd0);
    chk("reset.i_set",   32'(bus.sreg_i_set),    32'd0);
    chk("reset.mask",    32'(bus.tifr_clr_mask), 32'd0);
    reset = 1'b0;

    // Entry: sp=0x5F pc=0x2A3 TIM0_OVF.
    bus.sp = 8'h5F; bus.pc = 10'h2A3; bus.vector = V_OVF;
    bus.irq = 1'b1; bus.instr_boundary = 1'b1;
    @(negedge clk); chk_push("entry.push_lo", 8'h5F, 8'hA3, 3'd1);
    bus.vector = V_COMPB;                    // must be ignored once latched
    @(negedge clk); chk_push("entry.push_hi", 8'h5E, 8'h02, 3'd2);
    bus.irq = 1'b0; bus.instr_boundary = 1'b0;
    @(negedge clk); chk_jump("entry.jump", V_OVF, 8'h5D, M_OVF);
    @(negedge clk); chk_idle("entry.done");
    chk("entry.mem5f", 32'(mem[8'h5F]), 32'h0A3);
    chk("entry.mem5e", 32'(mem[8'h5E]), 32'h002);

    // Return with irq held high: RETI wins, then one boundary of hold.
    bus.sp = 8'h5D; bus.reti = 1'b1; bus.irq = 1'b1; bus.instr_boundary = 1'b1;
    @(negedge clk); chk_pop("ret.pop_hi", 8'h5E, 3'd4);
    bus.reti = 1'b0;
    @(negedge clk); chk_pop("ret.pop_lo", 8'h5F, 3'd5);
    @(negedge clk); chk_ret("ret.ret", 10'h2A3, 8'h5F);
    bus.sp = 8'h40; bus.pc = 10'h155; bus.vector = V_COMPB;
    @(negedge clk); chk_idle("b2b.idle");
    @(negedge clk); chk_idle("b2b.blocked");  // first boundary consumed by hold
    @(negedge clk); chk_push("b2b.push_lo", 8'h40, 8'h55, 3'd1);
    bus.irq = 1'b0; bus.instr_boundary = 1'b0;  // irq drop mid-entry
    @(negedge clk); chk_push("b2b.push_hi", 8'h3F, 8'h01, 3'd2);
    @(negedge clk); chk_jump("b2b.jump", V_COMPB, 8'h3E, M_COMPB);
    @(negedge clk); chk_idle("b2b.done");

    // Wrap: push from sp=0x01, then pop from sp=0xFF.
    bus.sp = 8'h01; bus.pc = 10'h3C7; bus.vector = V_COMPA;
    bus.irq = 1'b1; bus.instr_boundary = 1'b1;
    @(negedge clk); chk_push("wrap.push_lo", 8'h01, 8'hC7, 3'd1);
    bus.irq = 1'b0; bus.instr_boundary = 1'b0;
    @(negedge clk); chk_push("wrap.push_hi", 8'h00, 8'h03, 3'd2);
    @(negedge clk); chk_jump("wrap.jump", V_COMPA, 8'hFF, M_COMPA);
    @(negedge clk); chk_idle("wrap.idle");
    bus.sp = 8'hFF; bus.reti = 1'b1; bus.instr_boundary = 1'b1;
    @(negedge clk); chk_pop("wrap.pop_hi", 8'h00, 3'd4);
    bus.reti = 1'b0; bus.instr_boundary = 1'b0;
    @(negedge clk); chk_pop("wrap.pop_lo", 8'h01, 3'd5);
    @(negedge clk); chk_ret("wrap.ret", 10'h3C7, 8'h01);
    @(negedge clk); chk_idle("wrap.done");
    bus.instr_boundary = 1'b1;               // consume the hold with irq low
    @(negedge clk); chk_idle("hold.clear");

    // Reset during PUSH_HI aborts the entry.
    bus.sp = 8'h80; bus.pc = 10'h100; bus.vector = V_OVF; bus.irq = 1'b1;
    @(negedge clk); chk_push("abort.push_lo", 8'h80, 8'h00, 3'd1);
    bus.irq = 1'b0; bus.instr_boundary = 1'b0;
    @(negedge clk); chk_push("abort.push_hi", 8'h7F, 8'h01, 3'd2);
    reset = 1'b1;
    @(negedge clk); chk_idle("abort.reset");
    chk("abort.i_clr", 32'(bus.sreg_i_clr), 32'd0);
    reset = 1'b0;
    @(negedge clk); chk_idle("abort.no_jump");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
